// File: rtl/q_measure_seq.sv
`default_nettype none
// ============================================================================
// Module   : q_measure_seq
// Summary  : Measurement sequencer. It latches i_ref into the DAC and waits a
//            settle interval. It then averages 2**AVG_LOG2 ADC conversions
//            into q_measured and pulses ready. The optional conversion
//            timeout is enabled by defining Q_MEAS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module q_measure_seq #(
    parameter int BUS_WIDTH      = 10,
    parameter int SETTLE_CYCLES  = 16,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic                 dac_load,
    output logic                 adc_start,
    input  logic                 adc_valid,
    input  logic [BUS_WIDTH-1:0] adc_data,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 adc_timeout
);

    localparam int c_ACC_W = BUS_WIDTH + AVG_LOG2;
    localparam int c_NSAMP = 1 << AVG_LOG2;
    localparam int c_CNT_W = AVG_LOG2 + 1;
    localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_NSAMP - 1);

    generate
        if (SETTLE_CYCLES < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("q_measure_seq: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_SETTLE = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_dac_code;
    logic                 r_dac_load;
    logic                 r_adc_start;
    logic [BUS_WIDTH-1:0] r_q_measured;
    logic                 r_ready;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_SET_W-1:0]   r_settle;

    logic [c_ACC_W-1:0]   w_acc_next;
    logic [BUS_WIDTH-1:0] w_avg;

`ifdef Q_MEAS_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_wait;
    logic              r_tmo_hit;
    logic              r_adc_timeout;
`endif

    // Accumulator is wide enough for 2**AVG_LOG2 full-scale samples, so the sum never wraps.
    assign w_acc_next = r_acc + c_ACC_W'(adc_data);
    assign w_avg      = r_acc[c_ACC_W-1:AVG_LOG2];

    // adc_start is raised on the edge entering START so that the strobe and
    // the START state share a cycle; a one-cycle-later answer lands in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_dac_code   <= '0;
            r_dac_load   <= 1'b0;
            r_adc_start  <= 1'b0;
            r_q_measured <= '0;
            r_ready      <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_settle     <= '0;
`ifdef Q_MEAS_TIMEOUT_EN
            r_wait        <= '0;
            r_tmo_hit     <= 1'b0;
            r_adc_timeout <= 1'b0;
`endif
        end else begin
            r_dac_load  <= 1'b0;
            r_adc_start <= 1'b0;
            r_ready     <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_dac_code <= i_ref;
                    r_dac_load <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_settle   <= '0;
`ifdef Q_MEAS_TIMEOUT_EN
                    r_tmo_hit  <= 1'b0;
`endif
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle == c_SET_LAST) begin
                        r_adc_start <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_START: begin
`ifdef Q_MEAS_TIMEOUT_EN
                    r_wait  <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (adc_valid) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_adc_start <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
`ifdef Q_MEAS_TIMEOUT_EN
                    else if (r_wait == c_TO_LAST) begin
                        r_adc_timeout <= 1'b1;
                        r_tmo_hit     <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
`endif
                end
                S_DONE: begin
`ifdef Q_MEAS_TIMEOUT_EN
                    // An abandoned measurement leaves the previous result in place.
                    if (!r_tmo_hit) begin
                        r_q_measured <= w_avg;
                    end
`else
                    r_q_measured <= w_avg;
`endif
                    r_ready <= 1'b1;
                    r_state <= S_LOAD;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign dac_code   = r_dac_code;
    assign dac_load   = r_dac_load;
    assign adc_start  = r_adc_start;
    assign q_measured = r_q_measured;
    assign ready      = r_ready;

`ifdef Q_MEAS_TIMEOUT_EN
    assign adc_timeout = r_adc_timeout;
`else
    assign adc_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
